reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read core register file.
- Adds configurable width, depth, read/write port counts, write-to-read bypass, optional registered read, and a post-reset clear sequencer that zeroes one entry per cycle.
- Sits in the decode stage. Read ports feed operand fetch; write ports are driven by writeback lanes.

Parameters:
- XLEN, 32, data width per register
- NREGS, 32, number of architectural registers (power of 2, >=2)
- NRD, 2, number of read ports
- NWR, 1, number of write ports (1..4)
- ZERO_X0, 1, 1 = entry 0 is hardwired to zero (writes to it dropped, reads return 0)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
- READ_LAT, 0, 0 = combinational read; 1 = registered read
- AW, $clog2(NREGS), address width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_re  in  NRD  per-port read enable
- i_raddr  in  NRD*AW  read addresses; port k occupies [k*AW +: AW]
- o_rdata  out  NRD*XLEN  read data; port k occupies [k*XLEN +: XLEN]
- i_we  in  NWR  per-port write enable
- i_waddr  in  NWR*AW  write addresses
- i_wdata  in  NWR*XLEN  write data
- o_busy  out  1  high during reset and while the clear sequence runs; writes ignored, reads return 0

Behaviour:
- FSM states:
  - CLEAR: entered on any clk edge with rst_n=0. Clear pointer clr_ptr = ZERO_X0 ? 1 : 0. While rst_n=0, state and pointer are held there.
  - After rst_n returns high, each cycle writes 0 to entry clr_ptr and increments clr_ptr.
  - When clr_ptr==NREGS-1 is written, the next state is RUN.
  - Clear length is NREGS-ZERO_X0 cycles after the rst_n deassertion edge.
  - RUN: normal operation. rst_n=0 at any time (including mid-CLEAR) returns the FSM to CLEAR with the pointer reset.
- o_busy = (state==CLEAR). Reset value 1; it falls on the edge that completes the last clear write.
- During CLEAR:
  - all i_we are ignored
  - o_rdata = 0 on all ports
  - the READ_LAT=1 output register is also forced to 0
- Writes (RUN only): on the rising edge, entry i_waddr[j] <= i_wdata[j] for each j with i_we[j]=1.
  - With ZERO_X0=1, writes to address 0 are discarded.
  - Same-address collision between write ports: the highest port index wins; lower ports to that address are dropped.
- Reads, READ_LAT=0:
  - o_rdata[k] = 0 if i_re[k]=0, or if (ZERO_X0 and i_raddr[k]==0); otherwise the entry contents.
  - With BYPASS=1, a valid write in the same cycle to the same (nonzero-if-ZERO_X0) address returns the write data combinationally. The highest-index matching write port wins.
  - With BYPASS=0, the read returns the old value.
- Reads, READ_LAT=1:
  - When i_re[k]=1, o_rdata[k] is registered with the same value as the READ_LAT=0 expression. It is visible one cycle later.
  - When i_re[k]=0, o_rdata[k] holds its previous value.
  - Reset value is 0.
- Multiple read ports may target the same address in any combination; there are no structural hazards.
- Storage: entry 0 is not instantiated when ZERO_X0=1. No X is ever driven on o_rdata after the first reset edge.
- SIM-only (`ifdef SIM): per-write log line "x<addr>:<data>" appended to ID_log.csv, one line per committing write port.

Decomposition:
- Shared package/header (rtl/parameters.vh): default XLEN, NREGS, register-index constants, and the CLEAR/RUN state encoding localparams.
- One natural sub-module, rf_bypass_mux:
  - purely combinational, one instance per read port
  - takes the raw entry value plus NWR write lanes and applies the x0/enable/bypass priority rules
  - reused by the forwarding unit.

Test Plan:
- Reset/clear (defaults): hold rst_n=0 for 3 cycles, release.
  - o_busy stays 1 for exactly 31 cycles after release, then 0.
  - A write of 0xDEAD_BEEF to x5 during CLEAR is dropped: x5 reads 0 afterwards.
  - Reads during CLEAR return 0.
- Basic write/read: write x7=0x1234_5678. Next cycle read rs1=x7, rs2=x0 → 0x1234_5678 and 0. Write x0=0xFFFF_FFFF, then read x0 → 0.
- Bypass: BYPASS=1, same cycle write x3=0xA5A5_A5A5 and read x3 → 0xA5A5_A5A5 combinationally. BYPASS=0, same stimulus → old value 0.
- Write collision: NWR=2, both ports write x9 (port0=0x1111, port1=0x2222) → x9 reads 0x2222. Same-cycle bypass read also returns 0x2222.
- Registered read: READ_LAT=1. Write x4=0x55, then read x4 with i_re=1 → 0x55 appears one cycle later. Drop i_re, write x4=0x66 → output holds 0x55.
- Mid-clear reset: assert rst_n=0 at clear cycle 10, release → a full 31-cycle clear restarts. Registers written before the first reset read 0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared defaults and clear/run state encoding for the register file
package reg_file_mp_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
endpackage

// File: rtl/reg_file_mp_bypass_mux.sv
// rf_bypass_mux: per-read-port x0/enable/busy gating with highest-lane write forwarding
module rf_bypass_mux #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int NWR = 1,
  parameter int ZERO_X0 = 1,
  parameter int BYPASS = 1
)(
  input  logic              i_busy,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  input  logic [XLEN-1:0]   i_entry,
  input  logic [NWR-1:0]    i_we,
  input  logic [NWR*AW-1:0] i_waddr,
  input  logic [NWR*XLEN-1:0] i_wdata,
  output logic [XLEN-1:0]   o_data
);
  logic [XLEN-1:0] fwd;
  always_comb begin
    fwd = i_entry;
    for (int j = 0; j < NWR; j++)
      fwd = (BYPASS != 0 && i_we[j] && i_waddr[j*AW +: AW] == i_raddr) ? i_wdata[j*XLEN +: XLEN] : fwd;
    o_data = (i_busy || !i_re || (ZERO_X0 != 0 && i_raddr == '0)) ? '0 : fwd;
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with bypass, optional registered read and post-reset clear
module reg_file_mp import reg_file_mp_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int ZERO_X0 = 1,
  parameter int BYPASS = 1,
  parameter int READ_LAT = 0,
  localparam int AW = $clog2(NREGS)
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD-1:0]       i_re,
  input  logic [NRD*AW-1:0]    i_raddr,
  output logic [NRD*XLEN-1:0]  o_rdata,
  input  logic [NWR-1:0]       i_we,
  input  logic [NWR*AW-1:0]    i_waddr,
  input  logic [NWR*XLEN-1:0]  i_wdata,
  output logic                 o_busy
);
  logic [0:0] state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic busy;
  logic [XLEN-1:0] ent [NREGS];
  assign busy = state_q == ST_CLEAR;
  assign o_busy = busy;
  always_comb begin
    state_d = !rst_n ? ST_CLEAR : (busy && clr_ptr_q == AW'(NREGS - 1)) ? ST_RUN : state_q;
    clr_ptr_d = !rst_n ? AW'(ZERO_X0) : busy ? clr_ptr_q + AW'(1) : clr_ptr_q;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    clr_ptr_q <= clr_ptr_d;
  end
  genvar i, k;
  for (i = 0; i < NREGS; i++) begin : g_ent
    if (ZERO_X0 != 0 && i == 0) begin : g_zero
      assign ent[i] = '0;
    end else begin : g_reg
      logic [XLEN-1:0] ent_q, ent_d;
      always_comb begin
        ent_d = (busy && clr_ptr_q == AW'(i)) ? '0 : ent_q;
        for (int j = 0; j < NWR; j++)
          ent_d = (!busy && i_we[j] && i_waddr[j*AW +: AW] == AW'(i)) ? i_wdata[j*XLEN +: XLEN] : ent_d;
      end
      always_ff @(posedge clk) ent_q <= ent_d;
      assign ent[i] = ent_q;
    end
  end
  for (k = 0; k < NRD; k++) begin : g_rd
    logic [XLEN-1:0] rd;
    rf_bypass_mux #(
      .XLEN(XLEN), .AW(AW), .NWR(NWR), .ZERO_X0(ZERO_X0), .BYPASS(BYPASS)
    ) u_mux (
      .i_busy(busy),
      .i_re(i_re[k]),
      .i_raddr(i_raddr[k*AW +: AW]),
      .i_entry(ent[i_raddr[k*AW +: AW]]),
      .i_we(i_we),
      .i_waddr(i_waddr),
      .i_wdata(i_wdata),
      .o_data(rd)
    );
    if (READ_LAT != 0) begin : g_lat
      logic [XLEN-1:0] rdata_q, rdata_d;
      always_comb rdata_d = (!rst_n || busy) ? '0 : i_re[k] ? rd : rdata_q;
      always_ff @(posedge clk) rdata_q <= rdata_d;
      assign o_rdata[k*XLEN +: XLEN] = rdata_q;
    end else begin : g_comb
      assign o_rdata[k*XLEN +: XLEN] = rd;
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of clear, read/write, bypass, collision and registered read
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] re, we;
  logic [9:0] raddr, waddr;
  logic [63:0] wdata;
  logic [63:0] rdata, rdata_nb, rdata_rl;
  logic busy, busy_nb, busy_rl;
  int errors = 0;
  int checks = 0;
  int cnt;
  always #5 clk = ~clk;
  reg_file_mp #(.NWR(2), .BYPASS(1), .READ_LAT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_re(re), .i_raddr(raddr), .o_rdata(rdata),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .o_busy(busy));
  reg_file_mp #(.NWR(2), .BYPASS(0), .READ_LAT(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .i_re(re), .i_raddr(raddr), .o_rdata(rdata_nb),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .o_busy(busy_nb));
  reg_file_mp #(.NWR(2), .BYPASS(1), .READ_LAT(1)) u_rl (
    .clk(clk), .rst_n(rst_n), .i_re(re), .i_raddr(raddr), .o_rdata(rdata_rl),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .o_busy(busy_rl));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_clear(input string tag);
    cnt = 0;
    do begin
      tick;
      cnt++;
      if (cnt == 5) we = 2'b00;
    end while (busy === 1'b1 && cnt < 100);
    chk(tag, cnt, 32'd31);
  endtask
  initial begin
    rst_n = 1'b0;
    re = 2'b11;
    raddr = {5'd7, 5'd5};
    we = 2'b00;
    waddr = '0;
    wdata = '0;
    repeat (3) tick;
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_busy_rl", {31'b0, busy_rl}, 32'd1);
    chk("reset_read", rdata[31:0], 32'd0);
    chk("reset_read_rl", rdata_rl[31:0], 32'd0);
    rst_n = 1'b1;
    we = 2'b01;
    waddr = {5'd0, 5'd5};
    wdata = {32'd0, 32'hDEAD_BEEF};
    #1;
    chk("clear_read_bypass", rdata[31:0], 32'd0);
    wait_clear("clear_len");
    chk("clear_done_rl", {31'b0, busy_rl}, 32'd0);
    chk("clear_done_nb", {31'b0, busy_nb}, 32'd0);
    chk("dropped_x5", rdata[31:0], 32'd0);
    chk("dropped_x5_nb", rdata_nb[31:0], 32'd0);
    we = 2'b01;
    waddr = {5'd0, 5'd7};
    wdata = {32'd0, 32'h1234_5678};
    tick;
    we = 2'b00;
    raddr = {5'd0, 5'd7};
    #1;
    chk("read_x7", rdata[31:0], 32'h1234_5678);
    chk("read_x0", rdata[63:32], 32'd0);
    we = 2'b01;
    waddr = {5'd0, 5'd0};
    wdata = {32'd0, 32'hFFFF_FFFF};
    raddr = {5'd0, 5'd0};
    #1;
    chk("x0_no_bypass", rdata[31:0], 32'd0);
    tick;
    we = 2'b00;
    #1;
    chk("x0_after_write", rdata[31:0], 32'd0);
    we = 2'b01;
    waddr = {5'd0, 5'd3};
    wdata = {32'd0, 32'hA5A5_A5A5};
    raddr = {5'd0, 5'd3};
    #1;
    chk("bypass_on", rdata[31:0], 32'hA5A5_A5A5);
    chk("bypass_off", rdata_nb[31:0], 32'd0);
    tick;
    we = 2'b00;
    #1;
    chk("bypass_off_next", rdata_nb[31:0], 32'hA5A5_A5A5);
    we = 2'b11;
    waddr = {5'd9, 5'd9};
    wdata = {32'h2222, 32'h1111};
    raddr = {5'd9, 5'd0};
    #1;
    chk("collide_bypass", rdata[63:32], 32'h2222);
    tick;
    we = 2'b00;
    #1;
    chk("collide_stored", rdata[63:32], 32'h2222);
    chk("collide_stored_nb", rdata_nb[63:32], 32'h2222);
    re = 2'b01;
    #1;
    chk("re_gate", rdata[63:32], 32'd0);
    we = 2'b01;
    waddr = {5'd0, 5'd4};
    wdata = {32'd0, 32'h55};
    raddr = {5'd0, 5'd0};
    tick;
    we = 2'b00;
    raddr = {5'd0, 5'd4};
    #1;
    chk("rl_latency", rdata_rl[31:0], 32'd0);
    tick;
    chk("rl_read", rdata_rl[31:0], 32'h55);
    re = 2'b00;
    we = 2'b01;
    wdata = {32'd0, 32'h66};
    tick;
    we = 2'b00;
    #1;
    chk("rl_hold", rdata_rl[31:0], 32'h55);
    re = 2'b01;
    tick;
    chk("rl_new", rdata_rl[31:0], 32'h66);
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (10) tick;
    chk("midclear_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    tick;
    chk("midclear_rl_zero", rdata_rl[31:0], 32'd0);
    rst_n = 1'b1;
    wait_clear("midclear_len");
    re = 2'b11;
    raddr = {5'd9, 5'd7};
    #1;
    chk("cleared_x7", rdata[31:0], 32'd0);
    chk("cleared_x9", rdata[63:32], 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
